// File: rtl/sipo_pkg.sv
//------------------------------------------------------------------------------
// Module : sipo_pkg
// Brief  : Shared types, default width and parity helper for sipo_deser.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sipo_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 4;
    localparam int unsigned c_PARITY_MAX_W  = 64;

    typedef enum logic [0:0] {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

    // Callers zero-extend their word into the fixed-width argument; the padding
    // zeros leave the XOR reduction unchanged, so any WIDTH up to 64 works.
    function automatic logic f_even_parity(input logic [c_PARITY_MAX_W-1:0] i_vec);
        return ^i_vec;
    endfunction

endpackage : sipo_pkg

`default_nettype wire

// File: rtl/sipo_deser_if.sv
//------------------------------------------------------------------------------
// Module : sipo_deser_if
// Brief  : Serial input / parallel output bundle for sipo_deser.
//          parity_err exists only when SIPO_PARITY_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);

    logic             serial_in;
    logic             shift_en;
    logic             clear;
    logic [WIDTH-1:0] parallel_out;
    logic             valid;
    logic             busy;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output serial_in,
        output shift_en,
        output clear,
        input  parallel_out,
        input  valid,
`ifdef SIPO_PARITY_EN
        input  parity_err,
`endif
        input  busy
    );

    modport slave (
        input  serial_in,
        input  shift_en,
        input  clear,
        output parallel_out,
        output valid,
`ifdef SIPO_PARITY_EN
        output parity_err,
`endif
        output busy
    );

endinterface : sipo_deser_if

`default_nettype wire

// File: rtl/sipo_deser.sv
//------------------------------------------------------------------------------
// Module : sipo_deser
// Brief  : MSB-first serial-in / parallel-out deserializer with valid strobe.
//          Define SIPO_PARITY_EN to expect a trailing even-parity bit per word.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [WIDTH-1:0] r_parallel;
    logic [WIDTH-1:0] w_parallel_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [WIDTH-1:0] w_shifted;
`ifdef SIPO_PARITY_EN
    logic             r_parity_err;
    logic             w_parity_err_nxt;
`endif

    assign w_shifted = {r_sreg[WIDTH-2:0], bus.serial_in};

    always_comb begin
        w_state_nxt    = r_state;
        w_sreg_nxt     = r_sreg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_parallel_nxt = r_parallel;
        w_valid_nxt    = 1'b0;
`ifdef SIPO_PARITY_EN
        w_parity_err_nxt = r_parity_err;
`endif

        // clear outranks shift_en, so a bit sampled alongside it is dropped
        if (bus.clear) begin
            w_state_nxt   = S_DATA;
            w_sreg_nxt    = '0;
            w_bit_cnt_nxt = '0;
        end else if (bus.shift_en) begin
            case (r_state)
                S_DATA: begin
                    w_sreg_nxt = w_shifted;
                    if (r_bit_cnt == c_LAST_IDX) begin
                        w_bit_cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
                        w_state_nxt    = S_PARITY;
`else
                        w_parallel_nxt = w_shifted;
                        w_valid_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                S_PARITY: begin
                    w_state_nxt      = S_DATA;
                    w_parallel_nxt   = r_sreg;
                    w_valid_nxt      = 1'b1;
                    w_parity_err_nxt = f_even_parity(c_PARITY_MAX_W'(r_sreg)) ^ bus.serial_in;
                end
`endif
                default: begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end

        w_busy_nxt = (w_bit_cnt_nxt != '0) || (w_state_nxt == S_PARITY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_DATA;
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_parallel <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_sreg     <= w_sreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_parallel <= w_parallel_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
`ifdef SIPO_PARITY_EN
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    assign bus.parallel_out = r_parallel;
    assign bus.valid        = r_valid;
    assign bus.busy         = r_busy;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err   = r_parity_err;
`endif

endmodule : sipo_deser

`default_nettype wire

// File: tb/tb_sipo_deser.sv
//------------------------------------------------------------------------------
// Module : tb_sipo_deser
// Brief  : Directed plus random stimulus against a bit-queue reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    sipo_deser_if #(.WIDTH(WIDTH)) bus ();

    sipo_deser #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: the bits of the frame in flight, oldest first
    logic             q_bits[$];
    logic [WIDTH-1:0] exp_par   = '0;
    logic             exp_valid = 1'b0;
    logic             exp_busy  = 1'b0;
    logic             exp_perr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic se, input logic si, input logic clr);
        logic [WIDTH-1:0] word;
        logic             x;
        exp_valid = 1'b0;
        if (r) begin
            q_bits.delete();
            exp_par  = '0;
            exp_perr = 1'b0;
        end else if (clr) begin
            q_bits.delete();
        end else if (se) begin
            q_bits.push_back(si);
            if (q_bits.size() == FRAME) begin
                word = '0;
                x    = 1'b0;
                for (int i = 0; i < WIDTH; i++) word = {word[WIDTH-2:0], q_bits[i]};
                for (int i = 0; i < FRAME; i++) x = x ^ q_bits[i];
                exp_par   = word;
                exp_valid = 1'b1;
                if (FRAME > WIDTH) exp_perr = x;
                q_bits.delete();
            end
        end
        exp_busy = (q_bits.size() != 0);
    endtask

    task automatic step(input logic r, input logic se, input logic si, input logic clr);
        rst           = r;
        bus.shift_en  = se;
        bus.serial_in = si;
        bus.clear     = clr;
        @(posedge clk);
        model_edge(r, se, si, clr);
        #1;
        check("parallel_out", 32'(bus.parallel_out), 32'(exp_par));
        check("valid",        32'(bus.valid),        32'(exp_valid));
        check("busy",         32'(bus.busy),         32'(exp_busy));
`ifdef SIPO_PARITY_EN
        check("parity_err",   32'(bus.parity_err),   32'(exp_perr));
`endif
    endtask

    // n bits of 'bits', MSB first, with 'gap' idle cycles after every bit but the last
    task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            if (i != 0) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.serial_in = 1'b0;
        bus.shift_en  = 1'b0;
        bus.clear     = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_par",   32'(bus.parallel_out), 32'h0);
        check("reset_valid", 32'(bus.valid),        32'h0);
        check("reset_busy",  32'(bus.busy),         32'h0);
        idle(2);

`ifndef SIPO_PARITY_EN
        // basic word
        send_bits(32'b1011, 4, 0);
        check("basic_par",   32'(bus.parallel_out), 32'hB);
        check("basic_valid", 32'(bus.valid),        32'h1);
        check("basic_busy",  32'(bus.busy),         32'h0);
        idle(2);
        // gapped bits
        send_bits(32'b0110, 4, 3);
        check("gap_par", 32'(bus.parallel_out), 32'h6);
        idle(2);
        // back-to-back words
        send_bits(32'b1100, 4, 0);
        check("b2b_first", 32'(bus.parallel_out), 32'hC);
        send_bits(32'b0101, 4, 0);
        check("b2b_second", 32'(bus.parallel_out), 32'h5);
        idle(2);
        // clear mid-word, coincident with a sampled bit
        send_bits(32'b11, 2, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_busy", 32'(bus.busy),         32'h0);
        check("clear_par",  32'(bus.parallel_out), 32'h5);
        send_bits(32'b0011, 4, 0);
        check("after_clear_par", 32'(bus.parallel_out), 32'h3);
        // clear on the would-be last bit
        send_bits(32'b101, 3, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_last_valid", 32'(bus.valid), 32'h0);
        idle(2);
        // reset mid-word
        send_bits(32'b111, 3, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_par",  32'(bus.parallel_out), 32'h0);
        check("rst_mid_busy", 32'(bus.busy),         32'h0);
        send_bits(32'b1001, 4, 0);
        check("after_rst_par", 32'(bus.parallel_out), 32'h9);
`else
        send_bits(32'b1011_1, 5, 0);
        check("par_ok_par",   32'(bus.parallel_out), 32'hB);
        check("par_ok_valid", 32'(bus.valid),        32'h1);
        check("par_ok_err",   32'(bus.parity_err),   32'h0);
        idle(2);
        send_bits(32'b1011_0, 5, 0);
        check("par_bad_valid", 32'(bus.valid),      32'h1);
        check("par_bad_err",   32'(bus.parity_err), 32'h1);
        idle(3);
        // clear while waiting for the parity bit
        send_bits(32'b0110, 4, 0);
        check("par_wait_busy", 32'(bus.busy), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("par_abort_busy", 32'(bus.busy), 32'h0);
        send_bits(32'b0011_0, 5, 0);
        check("par_abort_next", 32'(bus.parallel_out), 32'h3);
`endif

        // randomized traffic, including occasional clear and reset
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 39) == 0));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sipo_deser

`default_nettype wire
